// File: rtl/ex_forward_hazard_ctrl.sv
// rtl/ex_forward_hazard_ctrl.sv - EX-stage operand forwarding and load-use hazard controller
//
// Keeps shadow copies of destination-register info for ID/EX, EX/MEM and
// MEM/WB, drives the EX operand-select buses, inserts a one-cycle bubble on
// load-use hazards and counts stall cycles (saturating).
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   hold                  - global freeze; all state holds, stall outputs forced 0
//   id_valid              - ID stage holds a real instruction
//   id_rs, id_rt          - ID source registers
//   id_uses_rs/rt         - source operand is actually read
//   id_dest               - ID destination register
//   id_reg_write          - ID instruction writes id_dest
//   id_mem_read           - ID instruction is a load
//   fwd_a_sel, fwd_b_sel  - 00 ID/EX, 10 EX/MEM, 01 MEM/WB, 11 zero
//   stall_if_id           - hold PC and IF/ID this cycle
//   flush_id_ex           - load a bubble into ID/EX at this edge
//   stall_count           - saturating count of load-use stall cycles
module ex_forward_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t state;
    state_t state_next;

    // ID/EX shadow
    logic [REG_W-1:0] ie_rs;
    logic [REG_W-1:0] ie_rt;
    logic             ie_uses_rs;
    logic             ie_uses_rt;
    logic [REG_W-1:0] ie_dest;
    logic             ie_reg_write;
    logic             ie_mem_read;
    // EX/MEM shadow
    logic [REG_W-1:0] em_dest;
    logic             em_reg_write;
    logic             em_mem_read;
    // MEM/WB shadow
    logic [REG_W-1:0] mw_dest;
    logic             mw_reg_write;

    logic hazard;
    logic bubble;

    // A load in EX/MEM has no result yet, so it is skipped and the lookup
    // falls through to MEM/WB; the load-use stall keeps that case from
    // ever mattering to a dependent instruction.
    function automatic logic [1:0] fwd_sel(
        input logic             uses,
        input logic [REG_W-1:0] src,
        input logic             e_wr,
        input logic [REG_W-1:0] e_dest,
        input logic             e_load,
        input logic             m_wr,
        input logic [REG_W-1:0] m_dest
    );
        if (!uses)                                   return 2'b00;
        else if (src == '0)                          return 2'b11;
        else if (e_wr && e_dest == src && !e_load)   return 2'b10;
        else if (m_wr && m_dest == src)              return 2'b01;
        else                                         return 2'b00;
    endfunction

    assign fwd_a_sel = fwd_sel(ie_uses_rs, ie_rs, em_reg_write, em_dest, em_mem_read,
                               mw_reg_write, mw_dest);
    assign fwd_b_sel = fwd_sel(ie_uses_rt, ie_rt, em_reg_write, em_dest, em_mem_read,
                               mw_reg_write, mw_dest);

    assign hazard = id_valid && ie_mem_read && ie_reg_write && (ie_dest != '0) &&
                    ((id_uses_rs && id_rs == ie_dest) || (id_uses_rt && id_rt == ie_dest));

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)       state <= RUN;
        else if (!hold)  state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (hazard) state_next = STALL;
            STALL:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // FSM outputs; hold suppresses the stall so it is taken once hold drops
    always_comb begin
        stall_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (state == RUN && hazard && !hold) begin
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    assign bubble = flush_id_ex || !id_valid;

    // Shadow pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_rs        <= '0;
            ie_rt        <= '0;
            ie_uses_rs   <= 1'b0;
            ie_uses_rt   <= 1'b0;
            ie_dest      <= '0;
            ie_reg_write <= 1'b0;
            ie_mem_read  <= 1'b0;
            em_dest      <= '0;
            em_reg_write <= 1'b0;
            em_mem_read  <= 1'b0;
            mw_dest      <= '0;
            mw_reg_write <= 1'b0;
        end else if (!hold) begin
            ie_rs        <= bubble ? '0   : id_rs;
            ie_rt        <= bubble ? '0   : id_rt;
            ie_uses_rs   <= bubble ? 1'b0 : id_uses_rs;
            ie_uses_rt   <= bubble ? 1'b0 : id_uses_rt;
            ie_dest      <= bubble ? '0   : id_dest;
            ie_reg_write <= bubble ? 1'b0 : id_reg_write;
            ie_mem_read  <= bubble ? 1'b0 : id_mem_read;
            em_dest      <= ie_dest;
            em_reg_write <= ie_reg_write;
            em_mem_read  <= ie_mem_read;
            mw_dest      <= em_dest;
            mw_reg_write <= em_reg_write;
        end
    end

    // Stall counter; flush_id_ex is already gated by hold
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (flush_id_ex && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_ex_forward_hazard_ctrl.sv
// tb/tb_ex_forward_hazard_ctrl.sv - self-checking bench for ex_forward_hazard_ctrl
module tb_ex_forward_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, hold, id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic [4:0] id_rs, id_rt, id_dest;
    logic [1:0] fa, fb, fa2, fb2;
    logic       st, fl, st2, fl2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    ex_forward_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_a_sel(fa), .fwd_b_sel(fb), .stall_if_id(st), .flush_id_ex(fl),
        .stall_count(cnt)
    );

    ex_forward_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_if_id(st2), .flush_id_ex(fl2),
        .stall_count(cnt2)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit rw; bit mr; int dest; bit ur; bit ut; int rs; int rt;
    } instr_t;

    // Model: instructions in EX, MEM, WB (index 0 = EX, youngest first)
    instr_t pipe [3];
    bit     last_edge_stalled;
    int     m_cnt, m_cnt2;
    bit     m_valid = 1'b0;
    bit     m_stall;

    function automatic instr_t nop_instr();
        instr_t n;
        n.rw = 0; n.mr = 0; n.dest = 0; n.ur = 0; n.ut = 0; n.rs = 0; n.rt = 0;
        return n;
    endfunction

    // Search older producers (MEM, then WB) youngest first; a load still in
    // MEM has no value yet and cannot supply the operand.
    function automatic int ref_sel(bit uses, int r);
        if (!uses) return 0;
        if (r == 0) return 3;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].rw && pipe[k].dest == r) begin
                if (k == 1 && pipe[k].mr) continue;
                return (k == 1) ? 2 : 1;
            end
        end
        return 0;
    endfunction

    function automatic bit ref_hazard();
        instr_t e;
        e = pipe[0];
        return id_valid && e.mr && e.rw && e.dest != 0 &&
               ((id_uses_rs && int'(id_rs) == e.dest) || (id_uses_rt && int'(id_rt) == e.dest));
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        m_stall = !hold && !last_edge_stalled && ref_hazard();
        if (!m_valid) return;
        chk("fwd_a",       int'(fa),   ref_sel(pipe[0].ur, pipe[0].rs));
        chk("fwd_b",       int'(fb),   ref_sel(pipe[0].ut, pipe[0].rt));
        chk("stall_if_id", int'(st),   int'(m_stall));
        chk("flush_id_ex", int'(fl),   int'(m_stall));
        chk("stall_count", int'(cnt),  m_cnt);
        chk("fwd_a_sat",   int'(fa2),  ref_sel(pipe[0].ur, pipe[0].rs));
        chk("stall_sat",   int'(st2),  int'(m_stall));
        chk("count_sat",   int'(cnt2), m_cnt2);
    endtask

    task automatic drive(bit rst, bit hl, bit v, int rs, int rt, bit ur, bit ut,
                         int dest, bit rw, bit mr);
        @(negedge clk);
        reset = rst; hold = hl; id_valid = v;
        id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = ur; id_uses_rt = ut;
        id_dest = 5'(dest); id_reg_write = rw; id_mem_read = mr;
        #2;
        model_compare();
    endtask

    task automatic step();
        instr_t n;
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 3; k++) pipe[k] = nop_instr();
            last_edge_stalled = 0; m_cnt = 0; m_cnt2 = 0; m_valid = 1;
        end else if (!hold) begin
            n = nop_instr();
            if (id_valid && !m_stall) begin
                n.rw = id_reg_write; n.mr = id_mem_read; n.dest = int'(id_dest);
                n.ur = id_uses_rs; n.ut = id_uses_rt; n.rs = int'(id_rs); n.rt = int'(id_rt);
            end
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = n;
            last_edge_stalled = m_stall;
            if (m_stall) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        #1;
    endtask

    task automatic nop_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    endtask

    // writer of rd (ALU) / reader of rs,rt
    task automatic alu(int rd, int rs, int rt);
        drive(0, 0, 1, rs, rt, 1, 1, rd, 1, 0); step();
    endtask

    task automatic load_use(bit with_hold, int exp_cnt, int exp_cnt2);
        drive(0, 0, 1, 1, 0, 1, 0, 7, 1, 1); step();          // lw r7
        if (with_hold) begin
            drive(0, 1, 1, 7, 2, 1, 1, 8, 1, 0);
            chk("lu_hold_no_stall", int'(st), 0);
            step();
        end
        drive(0, 0, 1, 7, 2, 1, 1, 8, 1, 0);                  // add rs=r7
        chk("lu_stall", int'(st), 1);
        chk("lu_flush", int'(fl), 1);
        step();
        drive(0, 0, 1, 7, 2, 1, 1, 8, 1, 0);                  // re-presented add
        chk("lu_one_cycle", int'(st), 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_fwd_a", int'(fa), 1);
        chk("lu_count", int'(cnt), exp_cnt);
        chk("lu_count_sat", int'(cnt2), exp_cnt2);
        step();
        repeat (3) nop_cycle();
    endtask

    initial begin
        bit keep;
        int rs, rt, dest;
        bit v, ur, ut, rw, mr, hl, rst;
        for (int k = 0; k < 3; k++) pipe[k] = nop_instr();
        last_edge_stalled = 0; m_cnt = 0; m_cnt2 = 0;
        reset = 1; hold = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0;
        id_uses_rt = 0; id_dest = 0; id_reg_write = 0; id_mem_read = 0;

        // Reset with hold asserted for 2 cycles
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_fwd_a", int'(fa), 0);
        chk("rst_fwd_b", int'(fb), 0);
        chk("rst_stall", int'(st), 0);
        chk("rst_flush", int'(fl), 0);
        chk("rst_count", int'(cnt), 0);
        step();

        // EX/MEM forward
        alu(3, 1, 2); alu(4, 3, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("exmem_a", int'(fa), 2); chk("exmem_b", int'(fb), 2);
        step(); repeat (3) nop_cycle();

        // MEM/WB forward with one independent instruction between
        alu(3, 1, 2); alu(6, 1, 2); alu(4, 3, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("memwb_a", int'(fa), 1); chk("memwb_b", int'(fb), 1);
        step(); repeat (3) nop_cycle();

        // Priority: r5 written twice, then read
        alu(5, 1, 2); alu(5, 1, 2); alu(9, 5, 5);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("prio_a", int'(fa), 2);
        step(); repeat (3) nop_cycle();

        // Mixed: A from EX/MEM, B from MEM/WB
        alu(2, 1, 1); alu(4, 1, 1); alu(9, 4, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mix_a", int'(fa), 2); chk("mix_b", int'(fb), 1);
        step(); repeat (3) nop_cycle();

        // Load-use, then with hold in the hazard cycle
        load_use(0, 1, 1);
        load_use(1, 2, 2);

        // Register 0: load writing r0 then reader of r0
        drive(0, 0, 1, 1, 0, 1, 0, 0, 1, 1); step();
        drive(0, 0, 1, 0, 0, 1, 1, 9, 1, 0);
        chk("r0_no_stall", int'(st), 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_fwd_a", int'(fa), 3); chk("r0_fwd_b", int'(fb), 3);
        step(); repeat (3) nop_cycle();

        // Saturation of the 2-bit counter
        load_use(0, 3, 3);
        load_use(0, 4, 3);
        load_use(0, 5, 3);

        // Randomized phase; ID instruction re-presented while stalled or held
        keep = 0; v = 0; rs = 0; rt = 0; ur = 0; ut = 0; dest = 0; rw = 0; mr = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!keep) begin
                v = ($urandom_range(0, 9) != 0);
                rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
                ur = $urandom_range(0, 3) != 0; ut = $urandom_range(0, 1);
                dest = $urandom_range(0, 7);
                rw = $urandom_range(0, 3) != 0; mr = $urandom_range(0, 2) == 0;
            end
            hl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            drive(rst, hl, v, rs, rt, ur, ut, dest, rw, mr);
            keep = !rst && (hl || m_stall);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ex_forward_hazard_ctrl.md
# ex_forward_hazard_ctrl

Controller for the EX-stage operand forwarding multiplexers of the 5-stage pipeline.
- Keeps its own shadow copy of destination-register information for the ID/EX, EX/MEM and MEM/WB stages.
- Drives the two 2-bit operand-select buses, `fwd_a_sel` and `fwd_b_sel`.
- Detects load-use hazards and inserts a one-cycle bubble.
- Counts stall cycles for performance monitoring.

It sits beside the ID/EX pipeline register and receives decode information from the ID stage.

## Interface
Parameters:
- `REG_W`, default 5: register-index width.
- `CNT_W`, default 16: stall-counter width.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `hold`  in  1: global pipeline freeze (memory wait). All internal state holds.
- `id_valid`  in  1: ID stage holds a real instruction.
- `id_rs`, `id_rt`  in  REG_W: source registers of the ID instruction.
- `id_uses_rs`, `id_uses_rt`  in  1: source operand is actually read.
- `id_dest`  in  REG_W: destination register of the ID instruction.
- `id_reg_write`  in  1: ID instruction writes `id_dest`.
- `id_mem_read`  in  1: ID instruction is a load.
- `fwd_a_sel`, `fwd_b_sel`  out  2: operand selects for EX. Encoding:
  - 00 = ID/EX register value
  - 10 = EX/MEM result
  - 01 = MEM/WB value
  - 11 = constant zero
- `stall_if_id`  out  1: hold PC and IF/ID this cycle.
- `flush_id_ex`  out  1: load a bubble into ID/EX at this edge.
- `stall_count`  out  CNT_W: saturating count of load-use stall cycles.

## Operation
Shadow pipeline registers:
- **ID/EX shadow:** rs, rt, uses_rs, uses_rt, dest, reg_write, mem_read.
- **EX/MEM shadow:** dest, reg_write, mem_read.
- **MEM/WB shadow:** dest, reg_write.

Advance rules, applied every edge unless `hold`=1:
- ID→EX captures the ID inputs.
- If `flush_id_ex`=1 or `id_valid`=0, ID→EX captures a bubble instead: all enables 0, all indices 0.
- EX→MEM and MEM→WB copy the previous stage unconditionally.

Forward select for operand A, evaluated combinationally from the shadow registers. Operand B is identical, using rt/uses_rt.
- If uses_rs=0: sel = 00.
- Else if rs==0: sel = 11 (register 0 is never forwarded).
- Else if EX/MEM reg_write and EX/MEM dest==rs and EX/MEM mem_read=0: sel = 10.
- Else if MEM/WB reg_write and MEM/WB dest==rs: sel = 01.
- Else: sel = 00.
- EX/MEM has priority over MEM/WB.
- A load in EX/MEM is never forwarded from EX/MEM. The load-use stall guarantees this case cannot occur for a dependent instruction.

Load-use detection:
- hazard = `id_valid` & ID/EX mem_read & ID/EX reg_write & (ID/EX dest != 0) & ((`id_uses_rs` & `id_rs`==dest) | (`id_uses_rt` & `id_rt`==dest)).

FSM states:
- **RUN:**
  - hazard=1 and `hold`=0: assert `stall_if_id`=1 and `flush_id_ex`=1, increment `stall_count`, go to STALL.
  - Otherwise: both stall outputs 0.
- **STALL:**
  - `stall_if_id`=0 and `flush_id_ex`=0 unconditionally; return to RUN.
  - The load is now in EX/MEM and the dependent instruction enters EX next edge, forwarding from MEM/WB (01).
  - A second hazard on the same instruction is impossible. The FSM state still prevents back-to-back stalls.
- **`hold`=1:** stall outputs forced to 0; FSM, shadow registers and counter hold.

Counter:
- `stall_count` saturates at all-ones and never wraps.

## Timing
- Reset, synchronous on the first edge with `reset`=1:
  - FSM = RUN.
  - All shadow registers are bubbles.
  - `stall_count`=0.
  - Hence `fwd_a_sel`=`fwd_b_sel`=00, `stall_if_id`=0, `flush_id_ex`=0.
- `reset` overrides `hold`.
- Reset in STALL returns to RUN with the bubble already flushed; no residual stall.
- Select outputs are combinational from registered state, valid in the same cycle the instruction occupies EX. Zero added latency.
- Stall outputs are combinational from ID inputs and registered state, asserted in the same cycle the dependent instruction sits in ID.
- Load-use penalty is exactly 1 cycle.
- Both operands may forward simultaneously from different stages, e.g. A=10, B=01.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `hold`=1 → all selects 00, stalls 0, `stall_count`=0.
- **EX/MEM forward:**
  - Stimulus: `add r3` followed by `sub rs=r3, rt=r3`.
  - Required: when `sub` is in EX, `fwd_a_sel`=`fwd_b_sel`=10.
  - Variant: with one independent instruction between them, both selects = 01.
- **Priority:** `r5` written by two consecutive instructions, then read → sel=10, not 01.
- **Load-use:**
  - Stimulus: `lw r7` then `add rs=r7`.
  - Required: `stall_if_id`=`flush_id_ex`=1 for exactly one cycle and `stall_count`=1; `add` then sees `fwd_a_sel`=01.
  - Repeat with `hold` asserted in the hazard cycle: stall deferred until `hold` drops.
- **Register 0:** instruction writing `r0`, then a reader of `r0` → sel=11, no stall even if the writer is a load.
- **Saturation:** with `CNT_W`=2, generate 5 load-use stalls → `stall_count` stays 3.
